power_accum_ctrl: RTL and testbench
===================================

Name: power_accum_ctrl

Overview:
Parametrised successor to the fixed 8-entry power-emulator register bank. It holds a CSR slave with one programmable weight per clock-gating element (CGE). Over a programmed window it accumulates, every cycle, the sum of weights of the active CGEs through a 2-stage pipeline. It then reports the energy result and a done pulse, and sits between the host bus and the per-CGE activity taps.

Parameters:
BITS, 32, weight width per CGE (user accuracy)
CGES, 13, number of CGE channels (1..24)
WIN_W, 16, width of window-length register
AW, 5, slave address width; must satisfy 2^AW >= 8+CGES
SUM_W (derived), BITS+$clog2(CGES), per-cycle sum width
RES_W (derived), SUM_W+WIN_W, accumulator width; must be <= 64

Ports:
clk  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-high reset
s_read  in  1  read strobe
s_write  in  1  write strobe
s_addr  in  AW  word address
s_wdata  in  32  write data
s_rdata  out  32  registered read data
s_rvalid  out  1  high one cycle with s_rdata
act  in  CGES  per-CGE activity, sampled every RUN cycle
busy  out  1  high in RUN/DRAIN
fin  out  1  one-cycle done pulse

Behaviour:
- Reset: s_rdata=0, s_rvalid=0, busy=0, fin=0. All weights, WINDOW, result, done and peak are 0. FSM goes to IDLE. Reset mid-run aborts with no fin.
- Register map (word addr):
  - 0 CTRL. W: bit0 start, bit1 clear. R: bit0 busy, bit1 done.
  - 1 WINDOW[WIN_W-1:0].
  - 2 RESULT[31:0], read-only.
  - 3 RESULT[RES_W-1:32] zero-extended, read-only.
  - 4 CYCLES, the RUN cycles elapsed.
  - 5 PEAK, see Optional Feature; reads 0 if the feature is absent.
  - 8+i WEIGHT[i], i<CGES.
  - Unmapped addresses read 0; writes to them are ignored.
- Reads: s_rdata and s_rvalid are valid the cycle after the s_read edge. Read and write to the same address in the same cycle returns the old value.
- Writes to WINDOW or WEIGHT while busy are dropped.
- FSM IDLE -> RUN: on a write with CTRL.start=1 while IDLE. Clears the accumulator, CYCLES and done.
  - If WINDOW=0, go directly to DONE; result stays 0.
  - start while busy is ignored.
- RUN: each cycle, stage 1 registers sum = Σ act[i]?WEIGHT[i]:0 (SUM_W bits, no overflow). Stage 2 adds the stage-1 value into the accumulator. CYCLES increments. Leave after WINDOW cycles.
- DRAIN: 2 cycles to flush stage 1 and stage 2, then DONE.
- DONE: 1 cycle. fin=1, done bit set, then IDLE.
  - fin is high exactly WINDOW+3 cycles after the start-write edge.
  - done stays set until the next start or clear.
- CTRL.clear=1 zeroes result, CYCLES, done and peak in any state.
  - If busy, it aborts to IDLE with no fin.
  - clear together with start: clear wins and start is ignored.
- Accumulator cannot overflow by construction (window max 2^WIN_W-1).

Optional Feature:
Macro POWER_PEAK_EN.
- Defined: register PEAK (addr 5, low 32 bits of SUM_W) holds the maximum stage-1 sum seen during the current run. It is cleared at start and on clear.
- Undefined: no peak logic; addr 5 reads 0.

Test Plan:
- Weights w0=10, w1=20, w2=5; WINDOW=4; act=3'b011 held; start -> fin pulse at start+7 cycles, RESULT=120, CYCLES=4, done=1, busy low after fin.
- Same weights with act toggling 011,100,111,000 over WINDOW=4 -> RESULT=30+5+35+0=70; with POWER_PEAK_EN, PEAK=35.
- WINDOW=0, start -> fin at start+1, RESULT=0, done=1.
- Write WEIGHT0=99 and a second start mid-run -> both ignored; result matches the first scenario, 120.
- clear asserted 2 cycles into a WINDOW=10 run -> busy drops next cycle, no fin, RESULT=0, done=0. Separately, reset mid-run gives the same outcome, and all registers read 0.
- All weights set to 0xFFFFFFFF, act all-ones, WINDOW=0xFFFF -> RESULT=13×(2^32-1)×65535 exact across addr 2/3; read of addr 31 returns 0 with s_rvalid=1.

Source files
------------

// File: rtl/power_accum_ctrl.sv
// Power accumulator controller: CSR bank holding one weight per clock-gating
// element; over a programmed window it sums the weights of the active CGEs
// every cycle through a 2-stage pipeline and reports the energy total.
// Latency: reads return 1 cycle after s_read; fin pulses WINDOW+3 cycles after
//   the start write (1 cycle when WINDOW=0).
// Backpressure: none; the slave always accepts. WINDOW/WEIGHT writes are
//   dropped while busy.
// Optional feature: define POWER_PEAK_EN to add the PEAK register (addr 5).
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   s_read, s_write   host strobes; s_addr word address; s_wdata write data
//   s_rdata, s_rvalid registered read data, valid one cycle after s_read
//   act               per-CGE activity taps, sampled every RUN cycle
//   busy              high while running or draining the pipeline
//   fin               one-cycle completion pulse
module power_accum_ctrl #(
  parameter int BITS  = 32,
  parameter int CGES  = 13,
  parameter int WIN_W = 16,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_read,
  input  logic            s_write,
  input  logic [AW-1:0]   s_addr,
  input  logic [31:0]     s_wdata,
  output logic [31:0]     s_rdata,
  output logic            s_rvalid,
  input  logic [CGES-1:0] act,
  output logic            busy,
  output logic            fin
);

  localparam int SUM_W = BITS + $clog2(CGES);
  localparam int RES_W = SUM_W + WIN_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [BITS-1:0]  weight_q [CGES];
  logic [WIN_W-1:0] window_q;
  logic [WIN_W-1:0] cycles_q;
  logic [RES_W-1:0] acc_q;
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_d;
  logic             s1_vld_q;
  logic             drain_cnt_q;
  logic             busy_q;
  logic             fin_q;
  logic             done_q;
  logic [31:0]      rdata_q;
  logic [31:0]      rdata_d;
  logic             rvalid_q;
`ifdef POWER_PEAK_EN
  logic [SUM_W-1:0] peak_q;
`endif

  logic ctrl_wr;
  logic clear_req;
  logic start_req;

  // Clear outranks start when both bits are written together.
  assign ctrl_wr   = s_write && (s_addr == AW'(0));
  assign clear_req = ctrl_wr && s_wdata[1];
  assign start_req = ctrl_wr && s_wdata[0] && !s_wdata[1] && (state_q == S_IDLE);

  // Stage-1 combinational sum; SUM_W carries $clog2(CGES) guard bits.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < CGES; i++) begin
      if (act[i]) sum_d = sum_d + SUM_W'(weight_q[i]);
    end
  end

  // Read mux sampled on the s_read edge, so a same-cycle write returns old data.
  always_comb begin
    rdata_d = '0;
    if (s_addr == AW'(0))      rdata_d = {30'd0, done_q, busy_q};
    else if (s_addr == AW'(1)) rdata_d = 32'(window_q);
    else if (s_addr == AW'(2)) rdata_d = 32'(acc_q);
    else if (s_addr == AW'(3)) rdata_d = 32'(64'(acc_q) >> 32);
    else if (s_addr == AW'(4)) rdata_d = 32'(cycles_q);
`ifdef POWER_PEAK_EN
    else if (s_addr == AW'(5)) rdata_d = 32'(peak_q);
`endif
    for (int i = 0; i < CGES; i++) begin
      if (s_addr == AW'(8 + i)) rdata_d = 32'(weight_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      window_q    <= '0;
      cycles_q    <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      s1_vld_q    <= 1'b0;
      drain_cnt_q <= 1'b0;
      busy_q      <= 1'b0;
      fin_q       <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      for (int i = 0; i < CGES; i++) weight_q[i] <= '0;
`ifdef POWER_PEAK_EN
      peak_q      <= '0;
`endif
    end else begin
      fin_q    <= 1'b0;
      rvalid_q <= s_read;
      if (s_read) rdata_q <= rdata_d;

      // Configuration is frozen while a run is in flight.
      if (s_write && !busy_q) begin
        if (s_addr == AW'(1)) window_q <= WIN_W'(s_wdata);
        for (int i = 0; i < CGES; i++) begin
          if (s_addr == AW'(8 + i)) weight_q[i] <= BITS'(s_wdata);
        end
      end

      // Stage 1 captures the weighted sum; stage 2 folds it into the total.
      s1_vld_q <= 1'b0;
      if (state_q == S_RUN) begin
        sum_q    <= sum_d;
        s1_vld_q <= 1'b1;
        cycles_q <= cycles_q + WIN_W'(1);
      end
      if (s1_vld_q) begin
        acc_q <= acc_q + RES_W'(sum_q);
`ifdef POWER_PEAK_EN
        if (sum_q > peak_q) peak_q <= sum_q;
`endif
      end

      case (state_q)
        S_IDLE: begin
          if (start_req) begin
            acc_q    <= '0;
            cycles_q <= '0;
            done_q   <= 1'b0;
`ifdef POWER_PEAK_EN
            peak_q   <= '0;
`endif
            if (window_q == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // cycles_q counts completed RUN cycles, so this is the last one.
          if (cycles_q + WIN_W'(1) == window_q) begin
            state_q     <= S_DRAIN;
            drain_cnt_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
          end else begin
            drain_cnt_q <= 1'b1;
          end
        end
        S_DONE: begin
          fin_q   <= 1'b1;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Clear aborts any run without a completion pulse and flushes the pipe.
      if (clear_req) begin
        acc_q    <= '0;
        cycles_q <= '0;
        done_q   <= 1'b0;
        s1_vld_q <= 1'b0;
        busy_q   <= 1'b0;
        fin_q    <= 1'b0;
        state_q  <= S_IDLE;
`ifdef POWER_PEAK_EN
        peak_q   <= '0;
`endif
      end
    end
  end

  assign s_rdata  = rdata_q;
  assign s_rvalid = rvalid_q;
  assign busy     = busy_q;
  assign fin      = fin_q;

endmodule

// File: tb/tb_power_accum_ctrl.sv
// Directed bench for power_accum_ctrl with a cycle-indexed behavioural model:
// a run is described by its start cycle, window and abort cycle, from which
// busy/fin are predicted every cycle and register contents after each run.
module tb_power_accum_ctrl;

  localparam int CGES = 13;
  localparam int BIG  = 1 << 30;
`ifdef POWER_PEAK_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            s_read;
  logic            s_write;
  logic [4:0]      s_addr;
  logic [31:0]     s_wdata;
  logic [31:0]     s_rdata;
  logic            s_rvalid;
  logic [CGES-1:0] act;
  logic            busy;
  logic            fin;

  power_accum_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .s_read   (s_read),
    .s_write  (s_write),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .s_rvalid (s_rvalid),
    .act      (act),
    .busy     (busy),
    .fin      (fin)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state
  longint unsigned m_w [CGES];
  int              m_window;
  longint unsigned m_result;
  longint unsigned m_peak;
  int              m_cycles;
  logic            m_done;
  int              r_start = -BIG;
  int              r_win   = 0;
  int              r_end   = -BIG;
  int              last_fin_k = -1;
  bit              chk_en = 1'b0;
  logic [CGES-1:0] pats [4];
  logic [63:0]     big_exp;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  function automatic int fin_k(input int w);
    return (w == 0) ? 1 : w + 3;
  endfunction

  function automatic bit run_busy();
    int k;
    k = cyc - r_start;
    return (r_end == BIG) && (r_win > 0) && (k >= 0) && (k <= r_win + 1);
  endfunction

  function automatic bit run_idle();
    return (r_end != BIG) || ((cyc - r_start) >= fin_k(r_win));
  endfunction

  function automatic longint unsigned wsum(input logic [CGES-1:0] a);
    longint unsigned s;
    s = 0;
    for (int i = 0; i < CGES; i++) if (a[i]) s += m_w[i];
    return s;
  endfunction

  // Per-cycle check of busy/fin against the run description.
  always @(negedge clk) begin
    if (chk_en) begin : cmp
      int k;
      bit live;
      bit eb;
      bit ef;
      k    = cyc - r_start;
      live = (cyc >= r_start) && (cyc < r_end);
      eb   = live && (r_win > 0) && (k <= r_win + 1);
      ef   = live && (k == fin_k(r_win));
      check("busy", {63'd0, busy}, {63'd0, eb});
      check("fin", {63'd0, fin}, {63'd0, ef});
      if (fin === 1'b1) last_fin_k = k;
    end
  end

  // All driver tasks start and end just after a negedge.
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    int ai;
    ai = int'(a);
    if (ai == 0) begin
      if (d[1]) begin
        if (r_end > cyc + 1) r_end = cyc + 1;
        m_result = 0; m_cycles = 0; m_done = 1'b0; m_peak = 0;
      end else if (d[0] && run_idle()) begin
        r_start = cyc + 1; r_win = m_window; r_end = BIG;
        m_result = 0; m_cycles = 0; m_done = 1'b0; m_peak = 0;
      end
    end else if (!run_busy()) begin
      if (ai == 1) m_window = int'(d[15:0]);
      else if (ai >= 8 && ai < 8 + CGES) m_w[ai-8] = longint'(d);
    end
    s_write = 1'b1; s_addr = a; s_wdata = d;
    @(negedge clk);
    s_write = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [4:0] a, input logic [31:0] exp);
    s_read = 1'b1; s_addr = a;
    @(negedge clk);
    s_read = 1'b0;
    check({name, " rvalid"}, {63'd0, s_rvalid}, 64'd1);
    check(name, {32'd0, s_rdata}, {32'd0, exp});
  endtask

  task automatic drive_act(input logic [CGES-1:0] a);
    longint unsigned s;
    act = a;
    s = wsum(a);
    m_result += s;
    if (s > m_peak) m_peak = s;
  endtask

  task automatic wait_done();
    while ((cyc - r_start) <= fin_k(r_win) + 1) @(negedge clk);
    m_done = 1'b1;
    m_cycles = r_win;
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] pk;
    pk = PEAK_ON ? m_peak[31:0] : 32'd0;
    bus_read({tag, " ctrl"}, 5'd0, {30'd0, m_done, 1'b0});
    bus_read({tag, " res_lo"}, 5'd2, m_result[31:0]);
    bus_read({tag, " res_hi"}, 5'd3, m_result[63:32]);
    bus_read({tag, " cycles"}, 5'd4, 32'(m_cycles));
    bus_read({tag, " peak"}, 5'd5, pk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    act = '0;
    if (r_end > cyc + 1) r_end = cyc + 1;
    for (int i = 0; i < CGES; i++) m_w[i] = 0;
    m_window = 0; m_result = 0; m_peak = 0; m_cycles = 0; m_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; s_read = 1'b0; s_write = 1'b0; s_addr = '0; s_wdata = '0; act = '0;
    for (int i = 0; i < CGES; i++) m_w[i] = 0;
    m_window = 0; m_result = 0; m_peak = 0; m_cycles = 0; m_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst rvalid", {63'd0, s_rvalid}, 64'd0);
    check("rst rdata", {32'd0, s_rdata}, 64'd0);
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst fin", {63'd0, fin}, 64'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check_regs("post-reset");
    bus_read("post-reset w0", 5'd8, 32'd0);

    // T1: held activity 011 over 4 cycles -> 4*30
    bus_write(5'd8, 32'd10); bus_write(5'd9, 32'd20); bus_write(5'd10, 32'd5);
    bus_write(5'd1, 32'd4);
    last_fin_k = -1;
    bus_write(5'd0, 32'd1);
    for (int j = 0; j < 4; j++) begin drive_act(13'b011); @(negedge clk); end
    wait_done();
    check("t1 fin latency", 64'(last_fin_k), 64'd7);
    check_regs("t1");
    bus_read("t1 res literal", 5'd2, 32'd120);
    bus_read("t1 cycles literal", 5'd4, 32'd4);

    // T2: toggling activity -> 30+5+35+0
    pats[0] = 13'b011; pats[1] = 13'b100; pats[2] = 13'b111; pats[3] = 13'b000;
    last_fin_k = -1;
    bus_write(5'd0, 32'd1);
    for (int j = 0; j < 4; j++) begin drive_act(pats[j]); @(negedge clk); end
    wait_done();
    check_regs("t2");
    bus_read("t2 res literal", 5'd2, 32'd70);
    bus_read("t2 peak literal", 5'd5, PEAK_ON ? 32'd35 : 32'd0);

    // T3: zero window completes immediately
    bus_write(5'd1, 32'd0);
    last_fin_k = -1;
    bus_write(5'd0, 32'd1);
    wait_done();
    check("t3 fin latency", 64'(last_fin_k), 64'd1);
    check_regs("t3");
    bus_read("t3 ctrl literal", 5'd0, 32'd2);

    // Read and write of the same register in one cycle returns the old value
    s_read = 1'b1; s_write = 1'b1; s_addr = 5'd1; s_wdata = 32'd6;
    @(negedge clk);
    s_read = 1'b0; s_write = 1'b0;
    check("rw old value", {32'd0, s_rdata}, 64'd0);
    m_window = 6;
    bus_read("rw new value", 5'd1, 32'd6);

    // T4: weight write and second start mid-run are ignored
    bus_write(5'd1, 32'd4);
    last_fin_k = -1;
    bus_write(5'd0, 32'd1);
    for (int j = 0; j < 4; j++) begin
      drive_act(13'b011);
      if (j == 1) bus_write(5'd8, 32'd99);
      else if (j == 2) bus_write(5'd0, 32'd1);
      else @(negedge clk);
    end
    wait_done();
    check("t4 fin latency", 64'(last_fin_k), 64'd7);
    check_regs("t4");
    bus_read("t4 res literal", 5'd2, 32'd120);
    bus_read("t4 w0 kept", 5'd8, 32'd10);

    // T5: clear two cycles into a 10-cycle run
    bus_write(5'd1, 32'd10);
    last_fin_k = -1;
    bus_write(5'd0, 32'd1);
    for (int j = 0; j < 2; j++) begin drive_act(13'b111); @(negedge clk); end
    bus_write(5'd0, 32'd2);
    repeat (15) @(negedge clk);
    check("t5 no fin", 64'(last_fin_k), 64'hFFFF_FFFF_FFFF_FFFF);
    check_regs("t5");
    bus_read("t5 ctrl literal", 5'd0, 32'd0);

    // T5b: reset mid-run
    last_fin_k = -1;
    bus_write(5'd0, 32'd1);
    for (int j = 0; j < 3; j++) begin drive_act(13'b111); @(negedge clk); end
    do_reset();
    repeat (12) @(negedge clk);
    check("t5b no fin", 64'(last_fin_k), 64'hFFFF_FFFF_FFFF_FFFF);
    check_regs("t5b");
    bus_read("t5b window", 5'd1, 32'd0);
    bus_read("t5b w0", 5'd8, 32'd0);
    bus_read("t5b w2", 5'd10, 32'd0);

    // T6: saturated weights over the maximum window
    for (int i = 0; i < CGES; i++) bus_write(5'(8 + i), 32'hFFFF_FFFF);
    bus_write(5'd1, 32'h0000_FFFF);
    last_fin_k = -1;
    bus_write(5'd0, 32'd1);
    for (int j = 0; j < 65535; j++) begin drive_act({CGES{1'b1}}); @(negedge clk); end
    act = '0;
    wait_done();
    check("t6 fin latency", 64'(last_fin_k), 64'd65538);
    check_regs("t6");
    big_exp = 64'd13 * 64'hFFFF_FFFF * 64'd65535;
    bus_read("t6 res_lo literal", 5'd2, big_exp[31:0]);
    bus_read("t6 res_hi literal", 5'd3, big_exp[63:32]);
    bus_read("unmapped 31", 5'd31, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
